// File: rtl/op_sequencer_pkg.sv
// Shared definitions for op_sequencer: state encodings, opcode and condition codes,
// flag bit indices and the state-to-strobe decode helper.
package op_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD_A = 3'd1,
    S_LOAD_B = 3'd2,
    S_EXEC   = 3'd3,
    S_SHIFT  = 3'd4,
    S_WB     = 3'd5,
    S_DONE   = 3'd6,
    S_EVAL   = 3'd7
  } state_t;

  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;
  localparam logic [2:0] OP_BR  = 3'b101;

  localparam logic [1:0] COND_ALWAYS = 2'b00;
  localparam logic [1:0] COND_Z      = 2'b01;
  localparam logic [1:0] COND_N      = 2'b10;
  localparam logic [1:0] COND_NZ     = 2'b11;

  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       en_ra;
    logic       en_rb;
    logic       en_rr;
    logic       en_rpr;
    logic [2:0] alu_op;
    logic       shift_step;
  } outs_t;

  function automatic logic is_shift(input logic [2:0] op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

  function automatic logic cond_match(input logic [1:0] cond, input logic [1:0] flags);
    logic m;
    case (cond)
      COND_ALWAYS: m = 1'b1;
      COND_Z:      m = flags[FLAG_Z];
      COND_N:      m = flags[FLAG_N];
      COND_NZ:     m = ~flags[FLAG_Z];
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

  // Strobes for the state being entered; registered by the caller.
  function automatic outs_t decode_outs(input state_t ns, input logic [2:0] op);
    outs_t o;
    o = '0;
    case (ns)
      S_IDLE:   o = '0;
      S_LOAD_A: begin o.busy = 1'b1; o.en_ra = 1'b1; o.alu_op = op; end
      S_LOAD_B: begin o.busy = 1'b1; o.en_rb = 1'b1; o.alu_op = op; end
      S_EXEC:   begin o.busy = 1'b1; o.en_rr = is_shift(op); o.alu_op = op; end
      S_SHIFT:  begin o.busy = 1'b1; o.en_rr = 1'b1; o.shift_step = 1'b1; o.alu_op = op; end
      S_WB:     begin o.busy = 1'b1; o.en_rpr = 1'b1; o.en_rr = ~is_shift(op); o.alu_op = op; end
      S_DONE:   begin o.busy = 1'b1; o.done = 1'b1; end
      S_EVAL:   begin o.busy = 1'b1; o.alu_op = op; end
      default:  o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/op_sequencer_seq_step_cnt.sv
// Loadable down-counter for shift steps; saturates at zero, with zero and one detect.
module seq_step_cnt #(
  parameter int SHW = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           dec,
  input  logic [SHW-1:0] din,
  output logic           zero,
  output logic           one
);

  logic [SHW-1:0] cnt_r;

  // Count register: load wins over decrement, never wraps below zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {SHW{1'b0}};
    end else if (load) begin
      cnt_r <= din;
    end else if (dec && (cnt_r != {SHW{1'b0}})) begin
      cnt_r <= cnt_r - SHW'(1'b1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {SHW{1'b0}});
  assign one  = (cnt_r == SHW'(1'b1));

endmodule

// File: rtl/op_sequencer.sv
// ALU operation sequencer: steps one op through load/exec/shift/writeback.
// Optional branch evaluation is enabled by defining SEQ_BRANCH_EN.
module op_sequencer
  import op_sequencer_pkg::*;
#(
  parameter int W   = 8,
  parameter int SHW = $clog2(W)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     opcode,
  input  logic [SHW-1:0] shamt,
  output logic           busy,
  output logic           done,
  output logic           en_ra,
  output logic           en_rb,
  output logic           en_rr,
  output logic           en_rpr,
  output logic [2:0]     alu_op,
  output logic           shift_step
`ifdef SEQ_BRANCH_EN
  ,
  input  logic [1:0]     cond,
  input  logic [1:0]     flags,
  output logic           branch_taken
`endif
);

  state_t         state_r;
  state_t         next_state_s;
  logic [2:0]     op_r;
  logic [2:0]     op_s;
  logic [SHW-1:0] shamt_r;
  logic           accept_s;
  logic           cnt_load_s;
  logic           cnt_dec_s;
  logic           cnt_zero_s;
  logic           cnt_one_s;
  outs_t          outs_r;

  assign accept_s   = (state_r == S_IDLE) && start;
  assign cnt_load_s = (state_r == S_EXEC);
  assign cnt_dec_s  = (state_r == S_SHIFT);

  seq_step_cnt #(.SHW(SHW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load_s),
    .dec   (cnt_dec_s),
    .din   (shamt_r),
    .zero  (cnt_zero_s),
    .one   (cnt_one_s)
  );

  // Opcode seen by the decode: the incoming one while idle, the captured one afterwards.
  always_comb begin
    op_s = op_r;
    if (state_r == S_IDLE) begin
      op_s = opcode;
    end else begin
      op_s = op_r;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) next_state_s = S_LOAD_A;
        else       next_state_s = S_IDLE;
      end
      S_LOAD_A: begin
`ifdef SEQ_BRANCH_EN
        if (op_r == OP_BR)        next_state_s = S_EVAL;
        else if (is_shift(op_r))  next_state_s = S_EXEC;
        else                      next_state_s = S_LOAD_B;
`else
        if (is_shift(op_r)) next_state_s = S_EXEC;
        else                next_state_s = S_LOAD_B;
`endif
      end
      S_LOAD_B: next_state_s = S_EXEC;
      S_EXEC: begin
        if (is_shift(op_r) && (shamt_r != {SHW{1'b0}})) next_state_s = S_SHIFT;
        else                                             next_state_s = S_WB;
      end
      // Zero detect is a guard only; normal exit is on the last step.
      S_SHIFT: begin
        if (cnt_one_s || cnt_zero_s) next_state_s = S_WB;
        else                         next_state_s = S_SHIFT;
      end
      S_WB:   next_state_s = S_DONE;
      S_DONE: next_state_s = S_IDLE;
`ifdef SEQ_BRANCH_EN
      S_EVAL: next_state_s = S_DONE;
`endif
      default: next_state_s = S_IDLE;
    endcase
  end

  // State, captured operands and registered strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
      op_r    <= 3'b000;
      shamt_r <= {SHW{1'b0}};
      outs_r  <= '0;
    end else begin
      state_r <= next_state_s;
      if (accept_s) begin
        op_r    <= opcode;
        shamt_r <= shamt;
      end else begin
        op_r    <= op_r;
        shamt_r <= shamt_r;
      end
      outs_r <= decode_outs(next_state_s, op_s);
    end
  end

`ifdef SEQ_BRANCH_EN
  logic branch_taken_r;

  // Branch decision: cleared on each accepted start, set at the end of EVAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_taken_r <= 1'b0;
    end else if (accept_s) begin
      branch_taken_r <= 1'b0;
    end else if (state_r == S_EVAL) begin
      branch_taken_r <= cond_match(cond, flags);
    end else begin
      branch_taken_r <= branch_taken_r;
    end
  end

  assign branch_taken = branch_taken_r;
`endif

  assign busy       = outs_r.busy;
  assign done       = outs_r.done;
  assign en_ra      = outs_r.en_ra;
  assign en_rb      = outs_r.en_rb;
  assign en_rr      = outs_r.en_rr;
  assign en_rpr     = outs_r.en_rpr;
  assign alu_op     = outs_r.alu_op;
  assign shift_step = outs_r.shift_step;

endmodule

// File: tb/tb_op_sequencer.sv
// Scoreboard bench for op_sequencer: stimulus queues expected per-cycle strobe vectors,
// a monitor pops and compares one vector per cycle.
module tb_op_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] opcode;
  logic [2:0] shamt;
  logic       busy, done, en_ra, en_rb, en_rr, en_rpr, shift_step;
  logic [2:0] alu_op;
  logic       bt_dut;
`ifdef SEQ_BRANCH_EN
  logic [1:0] cond;
  logic [1:0] flags;
`endif

  always #5 clk = ~clk;

  op_sequencer #(.W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .shamt      (shamt),
    .busy       (busy),
    .done       (done),
    .en_ra      (en_ra),
    .en_rb      (en_rb),
    .en_rr      (en_rr),
    .en_rpr     (en_rpr),
    .alu_op     (alu_op),
    .shift_step (shift_step)
`ifdef SEQ_BRANCH_EN
    ,
    .cond         (cond),
    .flags        (flags),
    .branch_taken (bt_dut)
`endif
  );

`ifndef SEQ_BRANCH_EN
  assign bt_dut = 1'b0;
`endif

  // {bt, busy, done, ra, rb, rr, rpr, alu_op[2:0], step}
  logic [10:0] act_s;
  assign act_s = {bt_dut, busy, done, en_ra, en_rb, en_rr, en_rpr, alu_op, shift_step};

  logic [10:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  string       tag      = "init";
  logic        bt_m     = 1'b0;

  function automatic logic [10:0] mk(input logic bt, input logic bsy, input logic dn,
                                     input logic ra, input logic rb, input logic rr,
                                     input logic rpr, input logic [2:0] op, input logic st);
    return {bt, bsy, dn, ra, rb, rr, rpr, op, st};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
  endtask

  // Monitor: one expected vector per cycle while the scoreboard holds entries.
  always begin
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      logic [10:0] e;
      e = exp_q.pop_front();
      chk(tag, 32'(act_s), 32'(e));
    end
  end

  // Push the expected cycle sequence of one op (including the trailing idle cycle).
  task automatic push_op(input logic [2:0] op, input logic [2:0] sh, output int len);
    bt_m = 1'b0;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, op, 1'b0));
`ifdef SEQ_BRANCH_EN
    if (op == 3'b101) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b0));
      case (cond)
        2'b00:   bt_m = 1'b1;
        2'b01:   bt_m = flags[0];
        2'b10:   bt_m = flags[1];
        default: bt_m = ~flags[0];
      endcase
      exp_q.push_back(mk(bt_m, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
      exp_q.push_back(mk(bt_m, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
      len = 3;
      return;
    end
`endif
    if (op == 3'b110 || op == 3'b111) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, op, 1'b0));
      for (int i = 0; i < int'(sh); i++)
        exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, op, 1'b1));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, op, 1'b0));
      len = 4 + int'(sh);
    end else begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, op, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op, 1'b0));
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, op, 1'b0));
      len = 5;
    end
    exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0));
  endtask

  // Start at a negedge; returns at the negedge of the done cycle.
  task automatic issue(input string name, input logic [2:0] op, input logic [2:0] sh,
                       input logic hold);
    int len;
    @(negedge clk);
    tag    = name;
    start  = 1'b1;
    opcode = op;
    shamt  = sh;
    push_op(op, sh, len);
    @(negedge clk);
    if (!hold) start = 1'b0;
    repeat (len - 1) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    opcode = 3'b000;
    shamt  = 3'd0;
`ifdef SEQ_BRANCH_EN
    cond  = 2'b00;
    flags = 2'b00;
`endif
    #1;
    chk("reset_state", 32'(act_s), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    issue("add_seq", 3'b000, 3'd0, 1'b0);
    issue("sub_seq", 3'b011, 3'd2, 1'b0);
    issue("shl3_seq", 3'b110, 3'd3, 1'b0);
    issue("shl0_seq", 3'b110, 3'd0, 1'b0);

    // Abort in the second step of a 5-step shift.
    @(negedge clk);
    tag    = "abort_pre";
    start  = 1'b1;
    opcode = 3'b110;
    shamt  = 3'd5;
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b1));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outputs", 32'(act_s), 32'd0);
    chk("abort_cnt", 32'(dut.u_cnt.cnt_r), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tag   = "abort_post_idle";
    for (int i = 0; i < 3; i++) exp_q.push_back(11'd0);
    repeat (3) @(negedge clk);

    // start held high: one op per IDLE visit, back-to-back at done+1.
    issue("hold_add", 3'b001, 3'd0, 1'b1);
    issue("hold_shr", 3'b111, 3'd2, 1'b1);
    issue("hold_last", 3'b010, 3'd0, 1'b0);

    issue("shr7_seq", 3'b111, 3'd7, 1'b0);
    chk("shr7_cnt_end", 32'(dut.u_cnt.cnt_r), 32'd0);

`ifdef SEQ_BRANCH_EN
    cond  = 2'b01;
    flags = 2'b01;
    issue("br_z_taken", 3'b101, 3'd0, 1'b0);
    cond  = 2'b11;
    issue("br_nz_not", 3'b101, 3'd0, 1'b0);
    cond  = 2'b01;
    issue("br_z_again", 3'b101, 3'd0, 1'b0);
    issue("bt_clear", 3'b000, 3'd0, 1'b0);
`else
    issue("op101_plain", 3'b101, 3'd0, 1'b0);
`endif

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
